// File: rtl/instr_mem_loader.sv
// Instruction-memory writer: assembles big-endian words from a UART byte
// stream and writes them from address 0 while holding the CPU.
module instr_mem_loader #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] HLT_WORD = 32'h00000001,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [31:0]       shift, shift_nxt;
    logic [15:0]       to_cnt, to_cnt_nxt;
    logic              we_nxt, ready_nxt, hold_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wdata_nxt;
    logic [ADDR_W:0]   wc_nxt;
    logic              accept;
    logic              last;

    assign accept = rx_valid && rx_ready;
    // During WRITE mem_addr equals word_count, so all-ones means memory is full
    assign last   = (mem_addr == {ADDR_W{1'b1}});

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        shift_nxt    = shift;
        to_cnt_nxt   = to_cnt;
        we_nxt       = 1'b0;
        ready_nxt    = 1'b0;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        hold_nxt     = cpu_hold;
        done_nxt     = done;
        err_nxt      = err;
        wc_nxt       = word_count;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt    = LOAD;
                    byte_cnt_nxt = '0;
                    shift_nxt    = '0;
                    to_cnt_nxt   = '0;
                    addr_nxt     = '0;
                    wc_nxt       = '0;
                    err_nxt      = 1'b0;
                    done_nxt     = 1'b0;
                    hold_nxt     = 1'b1;
                    ready_nxt    = 1'b1;
                end
            end
            LOAD: begin
                ready_nxt = 1'b1;
                if (accept) begin
                    shift_nxt    = {shift[23:0], rx_data};
                    to_cnt_nxt   = '0;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = WRITE;
                        we_nxt    = 1'b1;
                        ready_nxt = 1'b0;
                        wdata_nxt = {shift[23:0], rx_data};
                        addr_nxt  = word_count[ADDR_W-1:0];
                    end
                end else if (byte_cnt != 2'd0) begin
                    if (to_cnt == TIMEOUT - 16'd1) begin
                        byte_cnt_nxt = '0;
                        shift_nxt    = '0;
                        to_cnt_nxt   = '0;
                        err_nxt      = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 16'd1;
                    end
                end
            end
            WRITE: begin
                wc_nxt = word_count + 1'b1;
                if (mem_wdata == HLT_WORD || last) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    hold_nxt  = 1'b0;
                    if (!last) addr_nxt = mem_addr + 1'b1;
                end else begin
                    state_nxt = LOAD;
                    ready_nxt = 1'b1;
                    addr_nxt  = mem_addr + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            shift      <= '0;
            to_cnt     <= '0;
            mem_we     <= 1'b0;
            rx_ready   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            shift      <= shift_nxt;
            to_cnt     <= to_cnt_nxt;
            mem_we     <= we_nxt;
            rx_ready   <= ready_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            cpu_hold   <= hold_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            word_count <= wc_nxt;
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction memory. It receives a byte stream from the UART receiver, assembles 32-bit big-endian instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It holds the pipeline while loading, which lets new programs be loaded without resynthesising the ROM contents. Loading ends when the HLT word is written or when memory is full.

Parameters:
ADDR_W, 10, instruction-memory address width (DEPTH = 2**ADDR_W = 1024 words)
HLT_WORD, 32'h00000001, terminator word; it is written to memory, then loading ends
TIMEOUT, 16'd50000, idle clocks allowed between bytes of a partially assembled word

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a load
rx_data  in  8  received byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte this cycle
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  write data
cpu_hold  out  1  stall/hold the pipeline (PC frozen)
done  out  1  load complete; program may run
err  out  1  sticky: a partial word was discarded on timeout
word_count  out  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset (rst_n=0, asynchronous) clears everything:
  - state=IDLE, byte_cnt=0, shift reg=0, timeout counter=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, rx_ready=0, done=0, err=0, word_count=0.
  - cpu_hold=1: the CPU stays held after reset until a load completes.
- Reset asserted mid-load aborts the load at once. A word already assembled but not yet written is never written.
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered.
- IDLE: rx_ready=0, cpu_hold=1. A start pulse moves to LOAD and clears word_count, mem_addr, byte_cnt, err and done.
- LOAD: rx_ready=1.
  - A byte is accepted on a cycle where rx_valid&&rx_ready.
  - Byte order: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - byte_cnt counts 0..3.
  - The cycle after the 4th byte is accepted, state=WRITE, with mem_wdata=assembled word and mem_addr=word_count.
- WRITE: exactly one cycle with mem_we=1 and rx_ready=0. A byte presented during WRITE is not consumed; the source holds it.
  - Next cycle: word_count increments and mem_addr=word_count+1.
  - If the word == HLT_WORD, or word_count+1 == DEPTH, go to DONE; otherwise go back to LOAD.
- Latency: 4th byte accepted at edge N, mem_we high during cycle N+1, rx_ready high again at cycle N+2.
- DONE: done=1, cpu_hold=0, rx_ready=0, mem_we=0. word_count holds its final value. A new start pulse re-enters LOAD, with the same clears as from IDLE.
- start is ignored in LOAD and WRITE.
- Timeout:
  - In LOAD with byte_cnt!=0, the counter increments each cycle no byte is accepted and resets on every accepted byte.
  - When it reaches TIMEOUT: byte_cnt=0, partial word discarded, err=1 (sticky until next start), stay in LOAD.
  - With byte_cnt==0 the counter is held at 0; waiting for the first byte of a word has no time limit.
- Wrap: mem_addr never wraps. The write at address DEPTH-1 always ends the load.
- The loader drives only the memory's write path. The fetch read path is untouched. The memory write port is sampled on clk.

Test Plan:
- Reset then load bytes 20 42 00 05 / 20 63 00 07 / 00 00 00 01, with rx_valid held high -> writes at addr0=32'h20420005, addr1=32'h20630007, addr2=32'h00000001; done=1, cpu_hold=0, word_count=3, one mem_we pulse per word.
- Same stream with rx_valid toggling 1-0-1-0 -> identical writes; check rx_ready=0 during each WRITE cycle and that no byte is lost or duplicated.
- Send 2 bytes, then idle TIMEOUT cycles, then 8C 05 00 00 00 00 00 01 -> err=1, addr0=32'h8C050000, addr1=HLT, done=1.
- Stream 1024 words of 32'h00432020 with no HLT -> last write at addr 1023, done=1, word_count=1024, no write to addr 0 after the first.
- Pull rst_n low after 2 bytes of word 1 -> all outputs at reset values immediately; no further mem_we; a subsequent start reloads from addr 0.
- In DONE, pulse start and send 00 00 00 01 -> err, done and word_count cleared; addr0=HLT; done=1 again with word_count=1.
